pc_branch_seq: RTL

//   Registered program-counter sequencer for the simpleCPU fetch stage. Each

---
 rtl/pc_branch_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pc_branch_seq.sv
// Registered program-counter sequencer: one branch op per enabled cycle, with
// PC-relative targets and a return-address stack for CALL/RET.
module pc_branch_seq #(
    parameter int unsigned     PC_W        = 12,
    parameter int unsigned     STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic [2:0]                         op,
    input  logic [2:0]                         flags,
    input  logic [PC_W-1:0]                    immd,
    output logic [PC_W-1:0]                    pc,
    output logic                               taken,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_err
);

    localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [2:0] {
        OpNext = 3'd0,
        OpBr   = 3'd1,
        OpBz   = 3'd2,
        OpBnz  = 3'd3,
        OpBc   = 3'd4,
        OpBn   = 3'd5,
        OpCall = 3'd6,
        OpRet  = 3'd7
    } op_e;

    logic [PC_W-1:0]    pc_q, pc_d;
    logic               taken_q, taken_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic [PC_W-1:0]    stack_q [STACK_DEPTH];
    logic [PC_W-1:0]    stack_d [STACK_DEPTH];

    op_e                op_s;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    tgt;
    logic               full;
    logic               empty;
    logic [PTR_W-1:0]   push_idx;
    logic [PTR_W-1:0]   pop_idx;
    logic               cond;

    assign op_s     = op_e'(op);
    assign pc_inc   = pc_q + PC_W'(1);
    assign tgt      = pc_q + immd + PC_W'(1);
    assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty    = (depth_q == '0);
    assign push_idx = depth_q[PTR_W-1:0];
    assign pop_idx  = PTR_W'(depth_q - DEPTH_W'(1));

    // flags = {neg, carry, zero}
    always_comb begin
        cond = 1'b0;
        unique case (op_s)
            OpBr:    cond = 1'b1;
            OpBz:    cond = flags[0];
            OpBnz:   cond = ~flags[0];
            OpBc:    cond = flags[1];
            OpBn:    cond = flags[2];
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        taken_d = taken_q;
        depth_d = depth_q;
        err_d   = err_q;
        stack_d = stack_q;
        if (en) begin
            pc_d    = pc_inc;
            taken_d = 1'b0;
            if (op_s == OpCall) begin
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    stack_d[push_idx] = pc_inc;
                    depth_d           = depth_q + DEPTH_W'(1);
                    pc_d              = tgt;
                    taken_d           = 1'b1;
                end
            end else if (op_s == OpRet) begin
                if (empty) begin
                    err_d = 1'b1;
                end else begin
                    pc_d    = stack_q[pop_idx];
                    depth_d = depth_q - DEPTH_W'(1);
                    taken_d = 1'b1;
                end
            end else if (cond) begin
                pc_d    = tgt;
                taken_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack contents are only meaningful below depth_q, so they need no reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign pc        = pc_q;
    assign taken     = taken_q;
    assign depth     = depth_q;
    assign stack_err = err_q;

endmodule
